// File: rtl/itof_pipe_if.sv
// rtl/itof_pipe_if.sv - operand/result handshake bundle for the int-to-float pipe
interface itof_pipe_if;
  logic [31:0] in_x;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_y;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output in_x, in_valid, out_ready,
    input  in_ready, out_y, out_valid
  );

  modport slave (
    input  in_x, in_valid, out_ready,
    output in_ready, out_y, out_valid
  );
endinterface

// File: rtl/itof_pipe.sv
// rtl/itof_pipe.sv - three-stage int32 to IEEE-754 single converter, round-to-nearest-even
module itof_pipe (
  input  logic clk,
  input  logic rst,
  itof_pipe_if.slave bus
);
  logic        v1, v2, v3;
  logic        s1, z1;
  logic [31:0] m1;
  logic        s2, z2;
  logic [7:0]  e2;
  logic [30:0] norm2;
  logic [31:0] y3;
  logic        adv1, adv2, adv3;

  // Each stage advances if it is empty or its successor can advance, so bubbles collapse
  assign adv3 = !v3 | bus.out_ready;
  assign adv2 = !v2 | adv3;
  assign adv1 = !v1 | adv2;

  assign bus.in_ready  = adv1;
  assign bus.out_valid = v3;
  assign bus.out_y     = y3;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
    end else if (adv1) begin
      v1 <= bus.in_valid;
      if (bus.in_valid) begin
        s1 <= bus.in_x[31];
        m1 <= bus.in_x[31] ? (~bus.in_x + 32'd1) : bus.in_x;
        z1 <= (bus.in_x == 32'd0);
      end
    end
  end

  logic [4:0]  lz;
  logic [30:0] norm;
  logic [7:0]  e;

  always_comb begin
    lz = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (m1[i]) lz = 5'(31 - i);
    end
  end

  // The leading one lands in bit 31 and is implicit, so only bits 30:0 are kept
  assign norm = 31'(m1 << lz);
  assign e    = 8'd158 - {3'b000, lz};

  always_ff @(posedge clk) begin
    if (rst) begin
      v2 <= 1'b0;
    end else if (adv2) begin
      v2    <= v1;
      s2    <= s1;
      z2    <= z1;
      e2    <= e;
      norm2 <= norm;
    end
  end

  logic [22:0] f;
  logic        g, st, l, rnd;
  logic [30:0] mag;
  logic [31:0] y_next;

  // A mantissa carry ripples into the exponent through the joint add
  always_comb begin
    f      = norm2[30:8];
    g      = norm2[7];
    st     = |norm2[6:0];
    l      = norm2[8];
    rnd    = g & (st | l);
    mag    = {e2, f} + {30'd0, rnd};
    y_next = z2 ? 32'd0 : {s2, mag};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v3 <= 1'b0;
      y3 <= 32'd0;
    end else if (adv3) begin
      v3 <= v2;
      if (v2) y3 <= y_next;
    end
  end
endmodule

// File: tb/tb_itof_pipe.sv
// tb/tb_itof_pipe.sv - directed and randomized bench for itof_pipe
module tb_itof_pipe;
  logic clk = 1'b0;
  logic rst;
  itof_pipe_if bus();

  itof_pipe dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] din[$];
  logic [31:0] got[$];
  int acc_cyc[$];
  int del_cyc[$];
  int stab_err, rdy_err, full_cyc;
  bit timeout;

  function automatic logic [31:0] ref_itof(input logic [31:0] x);
    longint v, m, q, rem, half;
    int p, sh;
    logic [7:0] ex;
    if (x == 32'd0) return 32'd0;
    v = longint'($signed(x));
    m = (v < 0) ? -v : v;
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    if (p <= 23) begin
      q = m << (23 - p);
    end else begin
      sh = p - 23;
      q = m >> sh;
      rem = m & ((64'sd1 << sh) - 1);
      half = 64'sd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
    end
    ex = 8'(127 + p);
    if (q[24]) begin
      q = q >> 1;
      ex = ex + 8'd1;
    end
    return {x[31], ex, q[22:0]};
  endfunction

  task automatic stream(input logic [63:0] vld_pat, input bit vld_always,
                        input logic [63:0] rdy_pat, input bit rdy_rand, input int max_cyc);
    int idx = 0;
    int occ = 0;
    int cyc = 0;
    bit pend = 0;
    bit prev_stall = 0;
    logic [31:0] prev_y = 32'd0;
    got.delete(); acc_cyc.delete(); del_cyc.delete();
    stab_err = 0; rdy_err = 0; full_cyc = 0;
    while ((idx < din.size() || got.size() < din.size()) && cyc < max_cyc) begin
      @(negedge clk);
      bus.in_valid = (idx < din.size()) && (vld_always || pend || (cyc < 64 && vld_pat[cyc]));
      pend = bus.in_valid;
      bus.in_x = bus.in_valid ? din[idx] : 32'hDEADBEEF;
      bus.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : (cyc < 64 ? rdy_pat[cyc] : 1'b1);
      #1;
      if (prev_stall && (bus.out_valid !== 1'b1 || bus.out_y !== prev_y)) stab_err++;
      if (bus.in_ready !== !(occ == 3 && !bus.out_ready)) rdy_err++;
      if (!bus.in_ready) full_cyc++;
      if (bus.in_valid && bus.in_ready) begin
        acc_cyc.push_back(cyc);
        idx++; occ++; pend = 0;
      end
      if (bus.out_valid && bus.out_ready) begin
        got.push_back(bus.out_y);
        del_cyc.push_back(cyc);
        occ--;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_y = bus.out_y;
      @(posedge clk);
      cyc++;
    end
    timeout = (got.size() != din.size());
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_x = 32'd0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.out_y !== 32'd0) begin errors++; $display("FAIL reset_out_y got %h want 00000000", bus.out_y); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_basic();
    logic [31:0] exp_q[$] = '{32'h3F800000, 32'hBF800000, 32'h00000000, 32'hCF000000};
    din = '{32'd1, 32'hFFFFFFFF, 32'd0, 32'h80000000};
    stream(64'd0, 1'b1, '1, 1'b0, 100);
    checks++; if (timeout) begin errors++; $display("FAIL basic_count got %0d want 4", got.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if ((i < got.size() ? got[i] : 32'hx) !== exp_q[i]) begin
        errors++; $display("FAIL basic_value[%0d] got %h want %h", i, (i < got.size() ? got[i] : 32'hx), exp_q[i]);
      end
    end
    if (got.size() == 4 && acc_cyc.size() == 4) begin
      checks++; if (del_cyc[0] - acc_cyc[0] != 3) begin errors++; $display("FAIL basic_latency got %0d want 3", del_cyc[0] - acc_cyc[0]); end
      checks++; if (del_cyc[3] - del_cyc[0] != 3) begin errors++; $display("FAIL basic_throughput got %0d want 3", del_cyc[3] - del_cyc[0]); end
    end
  endtask

  task automatic test_rounding();
    logic [31:0] exp_q[$] = '{32'h4F000000, 32'h4B800000, 32'h4B800002, 32'h4B800002, 32'hCB800002};
    din = '{32'h7FFFFFFF, 32'd16777217, 32'd16777219, 32'd16777221, 32'hFEFFFFFD};
    stream(64'd0, 1'b1, '1, 1'b0, 100);
    checks++; if (timeout) begin errors++; $display("FAIL round_count got %0d want 5", got.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if ((i < got.size() ? got[i] : 32'hx) !== exp_q[i]) begin
        errors++; $display("FAIL round_value[%0d] got %h want %h", i, (i < got.size() ? got[i] : 32'hx), exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_q[$] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                              32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000, 32'h41200000};
    din.delete();
    for (int i = 1; i <= 10; i++) din.push_back(32'(i));
    stream(64'd0, 1'b1, 64'hF0E1_C3A5_9600_4F0C, 1'b0, 200);
    checks++; if (timeout) begin errors++; $display("FAIL bp_count got %0d want 10", got.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if ((i < got.size() ? got[i] : 32'hx) !== exp_q[i]) begin
        errors++; $display("FAIL bp_value[%0d] got %h want %h", i, (i < got.size() ? got[i] : 32'hx), exp_q[i]);
      end
    end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL bp_stable got %0d want 0", stab_err); end
    checks++; if (rdy_err != 0) begin errors++; $display("FAIL bp_in_ready got %0d want 0", rdy_err); end
    checks++; if (full_cyc == 0) begin errors++; $display("FAIL bp_fill got %0d want >0", full_cyc); end
  endtask

  task automatic test_bubbles();
    logic [31:0] exp_q[$] = '{32'hC0A00000, 32'h42C80000, 32'h4E800000};
    din = '{32'hFFFFFFFB, 32'd100, 32'h40000001};
    stream(64'h49, 1'b0, ~64'h1FF, 1'b0, 100);
    checks++; if (timeout) begin errors++; $display("FAIL bub_count got %0d want 3", got.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if ((i < got.size() ? got[i] : 32'hx) !== exp_q[i]) begin
        errors++; $display("FAIL bub_value[%0d] got %h want %h", i, (i < got.size() ? got[i] : 32'hx), exp_q[i]);
      end
    end
    if (got.size() == 3 && acc_cyc.size() == 3) begin
      checks++; if (acc_cyc[2] != 6) begin errors++; $display("FAIL bub_accept got %0d want 6", acc_cyc[2]); end
      checks++; if (del_cyc[0] != 9) begin errors++; $display("FAIL bub_first_out got %0d want 9", del_cyc[0]); end
      checks++; if (del_cyc[2] - del_cyc[0] != 2) begin errors++; $display("FAIL bub_drain got %0d want 2", del_cyc[2] - del_cyc[0]); end
    end
    checks++; if (rdy_err != 0) begin errors++; $display("FAIL bub_in_ready got %0d want 0", rdy_err); end
    checks++; if (full_cyc == 0) begin errors++; $display("FAIL bub_held got %0d want >0", full_cyc); end
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_x = 32'(i + 7);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL rstmid_full got valid %b ready %b want 1 0", bus.out_valid, bus.in_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_x = 32'd55;
    bus.out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.out_y !== 32'd0) begin errors++; $display("FAIL rstmid_out_y got %h want 00000000", bus.out_y); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %b want 1", bus.in_ready); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      #1;
      if (bus.out_valid !== 1'b0) stale++;
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL rstmid_stale got %0d want 0", stale); end
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_random();
    int bad = 0;
    din = '{32'h80000000, 32'h7FFFFFFF, 32'd0, 32'hFFFFFFFF, 32'h00FFFFFF, 32'hFF000001};
    for (int i = 0; i < 2000; i++) din.push_back($urandom >> $urandom_range(0, 31));
    for (int i = 0; i < 500; i++) din.push_back($urandom);
    stream(64'd0, 1'b1, 64'd0, 1'b1, 20000);
    checks++; if (timeout) begin errors++; $display("FAIL rand_count got %0d want %0d", got.size(), din.size()); end
    for (int i = 0; i < din.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== ref_itof(din[i])) begin
        errors++;
        if (bad < 10) $display("FAIL rand_value[%0d] x %h got %h want %h", i, din[i], got[i], ref_itof(din[i]));
        bad++;
      end
    end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL rand_stable got %0d want 0", stab_err); end
    checks++; if (rdy_err != 0) begin errors++; $display("FAIL rand_in_ready got %0d want 0", rdy_err); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_backpressure();
    test_bubbles();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
